fetch_pc_sequencer: RTL and testbench

- Generates the fetch PC and its per-cycle control for the instruction-address stage (stg1ia).
- Drives that stage's PC, flush, predicted-next-PC and predicted-taken inputs.
- Arbitrates between reset entry, back-end redirects, halt, stall, branch-target-buffer prediction and sequential advance.
- Sits at pipeline stage 0, between the execute-stage redirect path and the BTB lookup.

---
 rtl/fetch_pc_sequencer_pkg.sv | 20 ++
 rtl/pc_next_sel.sv | 40 ++++
 rtl/fetch_pc_sequencer.sv | 125 ++++++++++++
 tb/tb_fetch_pc_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared sizes, state encodings and flush-counter width for the fetch PC sequencer.
package fetch_pc_sequencer_pkg;

    // Address width of the fetch path and its top bit index.
    localparam int SIZE_ADDR = 32;
    localparam int HBIT_ADDR = SIZE_ADDR - 1;

    // Width of the post-redirect bubble counter (bubble count 0..15).
    localparam int FLUSH_CNT_W = 4;

    // Sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } pcseq_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux plus predicted-next-PC / predicted-taken generation.
// Priority: redirect > halt > stall > BTB hit > sequential.
module pc_next_sel
    import fetch_pc_sequencer_pkg::*;
#(
    parameter logic [HBIT_ADDR:0] PC_STEP = 1
) (
    input  pcseq_state_t         state,
    input  logic [HBIT_ADDR:0]   pc,
    input  logic                 redirect_valid,
    input  logic [HBIT_ADDR:0]   redirect_pc,
    input  logic                 halt,
    input  logic                 stall,
    input  logic                 btb_hit,
    input  logic [HBIT_ADDR:0]   btb_target,
    output logic [HBIT_ADDR:0]   next_pc,
    output logic [HBIT_ADDR:0]   pred_pc,
    output logic                 pred_taken
);

    logic [HBIT_ADDR:0] seq_pc;
    logic               in_run;

    // Prediction only trusts the BTB while fetching; otherwise the PC is
    // expected to simply step. The next PC holds unless running freely
    // or a redirect arrives outside the reset cycle.
    always_comb begin
        seq_pc     = pc + PC_STEP;
        in_run     = (state == ST_RUN);
        pred_taken = btb_hit & in_run;
        pred_pc    = pred_taken ? btb_target : seq_pc;
        next_pc    = pc;
        if ((state != ST_RESET) && redirect_valid) begin
            next_pc = redirect_pc;
        end else if (in_run && !halt && !stall) begin
            next_pc = pred_pc;
        end
    end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: FSM, fetch PC register, post-redirect bubble counter
// and redirect event counter feeding the instruction-address stage.
module fetch_pc_sequencer
    import fetch_pc_sequencer_pkg::*;
#(
    parameter logic [HBIT_ADDR:0] RESET_PC     = '0,
    parameter logic [HBIT_ADDR:0] PC_STEP      = 1,
    parameter int unsigned        FLUSH_CYCLES = 2
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst_n,
    input  logic                 iw_stall,
    input  logic                 iw_halt,
    input  logic                 iw_redirect_valid,
    input  logic [HBIT_ADDR:0]   iw_redirect_pc,
    input  logic                 iw_btb_hit,
    input  logic [HBIT_ADDR:0]   iw_btb_target,
    output logic [HBIT_ADDR:0]   ow_pc,
    output logic                 ow_flush,
    output logic [HBIT_ADDR:0]   ow_pred_pc,
    output logic                 ow_pred_taken,
    output logic                 ow_fetch_active,
    output logic [15:0]          ow_redirect_cnt
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CYCLES[FLUSH_CNT_W-1:0];

    pcseq_state_t           state_reg;
    pcseq_state_t           state_next;
    pcseq_state_t           resume_state;
    pcseq_state_t           redirect_state;
    logic [HBIT_ADDR:0]     pc_reg;
    logic [HBIT_ADDR:0]     pc_next;
    logic [FLUSH_CNT_W-1:0] flush_cnt_reg;
    logic [FLUSH_CNT_W-1:0] flush_cnt_next;
    logic [15:0]            redirect_cnt_reg;

    pc_next_sel #(
        .PC_STEP (PC_STEP)
    ) u_pc_next_sel (
        .state          (state_reg),
        .pc             (pc_reg),
        .redirect_valid (iw_redirect_valid),
        .redirect_pc    (iw_redirect_pc),
        .halt           (iw_halt),
        .stall          (iw_stall),
        .btb_hit        (iw_btb_hit),
        .btb_target     (iw_btb_target),
        .next_pc        (pc_next),
        .pred_pc        (ow_pred_pc),
        .pred_taken     (ow_pred_taken)
    );

    // State, PC and bubble-counter registers.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state_reg     <= ST_RESET;
            pc_reg        <= RESET_PC;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    // Next-state logic; a zero bubble count skips FLUSH and resumes directly.
    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        resume_state   = iw_halt ? ST_HALT : (iw_stall ? ST_STALL : ST_RUN);
        redirect_state = (FLUSH_LOAD != '0) ? ST_FLUSH : resume_state;
        case (state_reg)
            ST_RESET: begin
                state_next = iw_halt ? ST_HALT : ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                if (iw_redirect_valid) begin
                    state_next     = redirect_state;
                    flush_cnt_next = FLUSH_LOAD;
                end else begin
                    state_next = resume_state;
                end
            end
            ST_FLUSH: begin
                if (iw_redirect_valid) begin
                    state_next     = redirect_state;
                    flush_cnt_next = FLUSH_LOAD;
                end else begin
                    flush_cnt_next = flush_cnt_reg - 1'b1;
                    if (flush_cnt_reg <= 1) begin
                        state_next = resume_state;
                    end
                end
            end
            ST_HALT: begin
                if (!iw_redirect_valid && !iw_halt) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase
    end

    // Redirect event counter, wraps; redirects during the reset cycle are ignored.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            redirect_cnt_reg <= '0;
        end else if (iw_redirect_valid && (state_reg != ST_RESET)) begin
            redirect_cnt_reg <= redirect_cnt_reg + 16'd1;
        end
    end

    // Output decode; a redirect invalidates the current fetch immediately.
    always_comb begin
        ow_pc           = pc_reg;
        ow_fetch_active = (state_reg == ST_RUN);
        ow_redirect_cnt = redirect_cnt_reg;
        ow_flush        = (state_reg == ST_RESET) || (state_reg == ST_FLUSH) ||
                          (state_reg == ST_HALT)  || iw_redirect_valid;
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Scoreboard bench for fetch_pc_sequencer: each driven cycle pushes its
// expected outputs, a negedge monitor pops and compares them.
module tb_fetch_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        btb_hit;
    logic [31:0] btb_target;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        fetch_active;
    logic [15:0] redirect_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        flush;
        logic [31:0] pred_pc;
        logic        pred_taken;
        logic        active;
        logic [15:0] rcnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_rcnt = '0;

    fetch_pc_sequencer #(
        .RESET_PC     (32'h100),
        .PC_STEP      (32'd1),
        .FLUSH_CYCLES (2)
    ) dut (
        .iw_clk            (clk),
        .iw_rst_n          (rst_n),
        .iw_stall          (stall),
        .iw_halt           (halt),
        .iw_redirect_valid (redirect_valid),
        .iw_redirect_pc    (redirect_pc),
        .iw_btb_hit        (btb_hit),
        .iw_btb_target     (btb_target),
        .ow_pc             (pc),
        .ow_flush          (flush),
        .ow_pred_pc        (pred_pc),
        .ow_pred_taken     (pred_taken),
        .ow_fetch_active   (fetch_active),
        .ow_redirect_cnt   (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // One cycle: drive inputs just after the edge, push what the spec says
    // the outputs must be during this cycle, then advance to the next edge.
    task automatic cyc(input string tag, input bit s, input bit h, input bit rv,
                       input logic [31:0] rpc, input bit hit, input logic [31:0] tgt,
                       input logic [31:0] epc, input bit eflush, input bit eactive);
        exp_t e;
        stall          = s;
        halt           = h;
        redirect_valid = rv;
        redirect_pc    = rpc;
        btb_hit        = hit;
        btb_target     = tgt;
        e.tag        = tag;
        e.pc         = epc;
        e.flush      = eflush;
        e.active     = eactive;
        e.pred_taken = hit && eactive;
        e.pred_pc    = (hit && eactive) ? tgt : epc + 32'd1;
        e.rcnt       = exp_rcnt;
        sb.push_back(e);
        if (rv) exp_rcnt = exp_rcnt + 16'd1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the oldest expectation against the settled outputs.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_val({e.tag, ".pc"},     {32'd0, pc},           {32'd0, e.pc});
            check_val({e.tag, ".flush"},  {63'd0, flush},        {63'd0, e.flush});
            check_val({e.tag, ".pred"},   {32'd0, pred_pc},      {32'd0, e.pred_pc});
            check_val({e.tag, ".taken"},  {63'd0, pred_taken},   {63'd0, e.pred_taken});
            check_val({e.tag, ".active"}, {63'd0, fetch_active}, {63'd0, e.active});
            check_val({e.tag, ".rcnt"},   {48'd0, redirect_cnt}, {48'd0, e.rcnt});
        end
    end

    task automatic check_reset_state(input string tag);
        check_val({tag, ".pc"},     {32'd0, pc},            64'h100);
        check_val({tag, ".flush"},  {63'd0, flush},         64'd1);
        check_val({tag, ".pred"},   {32'd0, pred_pc},       64'h101);
        check_val({tag, ".taken"},  {63'd0, pred_taken},    64'd0);
        check_val({tag, ".active"}, {63'd0, fetch_active},  64'd0);
        check_val({tag, ".rcnt"},   {48'd0, redirect_cnt},  {48'd0, exp_rcnt});
        check_val({tag, ".fcnt"},   {60'd0, dut.flush_cnt_reg}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 0; halt = 0; redirect_valid = 0;
        redirect_pc = '0; btb_hit = 0; btb_target = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        // reset then sequential run
        cyc("rst_cyc", 0,0,0,32'h0,  0,32'h0,   32'h100, 1,0);
        cyc("run0",    0,0,0,32'h0,  0,32'h0,   32'h100, 0,1);
        cyc("run1",    0,0,0,32'h0,  0,32'h0,   32'h101, 0,1);
        // BTB hit at 0x102
        cyc("btb",     0,0,0,32'h0,  1,32'h200, 32'h102, 0,1);
        cyc("btb_tgt", 0,0,0,32'h0,  0,32'h0,   32'h200, 0,1);
        // redirect to 0x300
        cyc("rd_N",    0,0,1,32'h300,0,32'h0,   32'h201, 1,1);
        cyc("rd_N1",   0,0,0,32'h0,  0,32'h0,   32'h300, 1,0);
        cyc("rd_N2",   0,0,0,32'h0,  0,32'h0,   32'h300, 1,0);
        cyc("rd_N3",   0,0,0,32'h0,  0,32'h0,   32'h300, 0,1);
        cyc("rd_seq",  0,0,0,32'h0,  0,32'h0,   32'h301, 0,1);
        // stall and redirect together
        cyc("sr_N",    1,0,1,32'h500,0,32'h0,   32'h302, 1,1);
        cyc("sr_f1",   1,0,0,32'h0,  0,32'h0,   32'h500, 1,0);
        cyc("sr_f2",   1,0,0,32'h0,  0,32'h0,   32'h500, 1,0);
        cyc("sr_stl",  1,0,0,32'h0,  0,32'h0,   32'h500, 0,0);
        cyc("sr_rel",  0,0,0,32'h0,  0,32'h0,   32'h500, 0,0);
        cyc("sr_run",  0,0,0,32'h0,  0,32'h0,   32'h500, 0,1);
        cyc("sr_seq",  0,0,0,32'h0,  0,32'h0,   32'h501, 0,1);
        // halt during FLUSH, redirect while halted
        cyc("hf_N",    0,0,1,32'h600,0,32'h0,   32'h502, 1,1);
        cyc("hf_f1",   0,1,0,32'h0,  0,32'h0,   32'h600, 1,0);
        cyc("hf_f2",   0,1,0,32'h0,  0,32'h0,   32'h600, 1,0);
        cyc("hf_halt", 0,1,0,32'h0,  0,32'h0,   32'h600, 1,0);
        cyc("hf_rd",   0,1,1,32'h400,0,32'h0,   32'h600, 1,0);
        cyc("hf_pc",   0,1,0,32'h0,  0,32'h0,   32'h400, 1,0);
        cyc("hf_rel",  0,0,0,32'h0,  0,32'h0,   32'h400, 1,0);
        cyc("hf_run",  0,0,0,32'h0,  0,32'h0,   32'h400, 0,1);
        cyc("hf_seq",  0,0,0,32'h0,  0,32'h0,   32'h401, 0,1);
        // wrap at all-ones
        cyc("wr_N",    0,0,1,32'hFFFF_FFFF,0,32'h0, 32'h402, 1,1);
        cyc("wr_f1",   0,0,0,32'h0,  0,32'h0,   32'hFFFF_FFFF, 1,0);
        cyc("wr_f2",   0,0,0,32'h0,  0,32'h0,   32'hFFFF_FFFF, 1,0);
        cyc("wr_ff",   0,0,0,32'h0,  0,32'h0,   32'hFFFF_FFFF, 0,1);
        cyc("wr_0",    0,0,0,32'h0,  0,32'h0,   32'h0,   0,1);
        cyc("wr_1",    0,0,0,32'h0,  0,32'h0,   32'h1,   0,1);
        // async reset mid-FLUSH
        cyc("ar_N",    0,0,1,32'h700,0,32'h0,   32'h2,   1,1);
        cyc("ar_f1",   0,0,0,32'h0,  0,32'h0,   32'h700, 1,0);
        #2;
        rst_n = 1'b0;
        exp_rcnt = '0;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("ar_rst",  0,0,0,32'h0,  0,32'h0,   32'h100, 1,0);
        cyc("ar_run",  0,0,0,32'h0,  0,32'h0,   32'h100, 0,1);
        cyc("ar_seq",  0,0,0,32'h0,  0,32'h0,   32'h101, 0,1);
        // stall outranks BTB hit; no prediction outside RUN
        cyc("bs_hit",  1,0,0,32'h0,  1,32'h800, 32'h102, 0,1);
        cyc("bs_stl",  0,0,0,32'h0,  1,32'h800, 32'h102, 0,0);
        cyc("bs_run",  0,0,0,32'h0,  0,32'h0,   32'h102, 0,1);
        cyc("bs_seq",  0,0,0,32'h0,  0,32'h0,   32'h103, 0,1);

        @(posedge clk);
        #1;
        check_val("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
